// File: rtl/vx_cache_port_relay.sv
// vx_cache_port_relay: elastic relay between the core's flattened dcache ports
// and the data cache. One request FIFO per lane, one response FIFO, a bounded
// outstanding-read counter and a RUN/DRAIN/SLEEP quiesce handshake.
module vx_cache_port_relay #(
  parameter int NUM_REQS    = 4,
  parameter int ADDR_WIDTH  = 30,
  parameter int TAG_WIDTH   = 8,
  parameter int REQ_DEPTH   = 2,
  parameter int RSP_DEPTH   = 2,
  parameter int MAX_PENDING = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQS-1:0]              core_req_valid,
  input  logic [NUM_REQS-1:0]              core_req_rw,
  input  logic [NUM_REQS*4-1:0]            core_req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]   core_req_addr,
  input  logic [NUM_REQS*32-1:0]           core_req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]    core_req_tag,
  output logic [NUM_REQS-1:0]              core_req_ready,
  output logic [NUM_REQS-1:0]              mem_req_valid,
  output logic [NUM_REQS-1:0]              mem_req_rw,
  output logic [NUM_REQS*4-1:0]            mem_req_byteen,
  output logic [NUM_REQS*ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [NUM_REQS*32-1:0]           mem_req_data,
  output logic [NUM_REQS*TAG_WIDTH-1:0]    mem_req_tag,
  input  logic [NUM_REQS-1:0]              mem_req_ready,
  input  logic                             mem_rsp_valid,
  input  logic [NUM_REQS-1:0]              mem_rsp_tmask,
  input  logic [NUM_REQS*32-1:0]           mem_rsp_data,
  input  logic [TAG_WIDTH-1:0]             mem_rsp_tag,
  output logic                             mem_rsp_ready,
  output logic                             core_rsp_valid,
  output logic [NUM_REQS-1:0]              core_rsp_tmask,
  output logic [NUM_REQS*32-1:0]           core_rsp_data,
  output logic [TAG_WIDTH-1:0]             core_rsp_tag,
  input  logic                             core_rsp_ready,
  input  logic                             drain_req,
  output logic                             drain_ack,
  output logic                             busy
);
  localparam int RPW    = $clog2(REQ_DEPTH);
  localparam int SPW    = $clog2(RSP_DEPTH);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  localparam logic [RPW-1:0]    RP_ONE   = RPW'(1);
  localparam logic [RPW:0]      RC_ONE   = (RPW + 1)'(1);
  localparam logic [RPW:0]      RC_FULL  = (RPW + 1)'(REQ_DEPTH);
  localparam logic [SPW-1:0]    SP_ONE   = SPW'(1);
  localparam logic [SPW:0]      SC_ONE   = (SPW + 1)'(1);
  localparam logic [SPW:0]      SC_FULL  = (SPW + 1)'(RSP_DEPTH);
  // Reads stop once another full-width read could overflow MAX_PENDING.
  localparam logic [PEND_W-1:0] BLOCK_TH = PEND_W'(MAX_PENDING - NUM_REQS);

  typedef struct packed {
    logic                  rw;
    logic [3:0]            byteen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
    logic [TAG_WIDTH-1:0]  tag;
  } req_t;

  typedef struct packed {
    logic [NUM_REQS-1:0]    tmask;
    logic [NUM_REQS*32-1:0] data;
    logic [TAG_WIDTH-1:0]   tag;
  } rsp_t;

  typedef enum logic [1:0] {RUN, DRAIN, SLEEP} state_t;

  state_t              state, state_n;
  logic                accept_en;
  logic [NUM_REQS-1:0] req_empty, req_full;
  logic                rsp_empty, rsp_full;
  logic [PEND_W-1:0]   pending, rd_inc, rsp_dec;
  logic                read_block, rsp_push, rsp_pop, idle;

  assign read_block = pending > BLOCK_TH;

  // ---------------- per-lane request FIFOs ----------------
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_lane
    req_t           slots [REQ_DEPTH];
    req_t           din, head;
    logic [RPW-1:0] rd_ptr, wr_ptr;
    logic [RPW:0]   cnt, cnt_n;
    logic           empty_r, full_r, push, pop;

    assign din  = {core_req_rw[i], core_req_byteen[i*4 +: 4],
                   core_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                   core_req_data[i*32 +: 32], core_req_tag[i*TAG_WIDTH +: TAG_WIDTH]};
    assign push = core_req_valid[i] & core_req_ready[i];
    assign pop  = mem_req_valid[i] & mem_req_ready[i];

    // Occupancy after this cycle's push/pop.
    always_comb begin
      cnt_n = cnt;
      case ({push, pop})
        2'b10:   cnt_n = cnt + RC_ONE;
        2'b01:   cnt_n = cnt - RC_ONE;
        default: cnt_n = cnt;
      endcase
    end

    // Pointers and registered full/empty flags.
    always_ff @(posedge clk) begin
      if (reset) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        cnt     <= '0;
        empty_r <= 1'b1;
        full_r  <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + RP_ONE;
        if (pop)  rd_ptr <= rd_ptr + RP_ONE;
        cnt     <= cnt_n;
        empty_r <= (cnt_n == '0);
        full_r  <= (cnt_n == RC_FULL);
      end
    end

    // Storage needs no reset: the head is only observed when non-empty.
    always_ff @(posedge clk) begin
      if (push) slots[wr_ptr] <= din;
    end

    assign head         = slots[rd_ptr];
    assign req_empty[i] = empty_r;
    assign req_full[i]  = full_r;

    assign core_req_ready[i] = ~reset & accept_en & ~full_r & (core_req_rw[i] | ~read_block);
    assign mem_req_valid[i]  = ~empty_r;
    assign mem_req_rw[i]     = head.rw;
    assign mem_req_byteen[i*4 +: 4]                  = head.byteen;
    assign mem_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]  = head.addr;
    assign mem_req_data[i*32 +: 32]                  = head.data;
    assign mem_req_tag[i*TAG_WIDTH +: TAG_WIDTH]     = head.tag;
  end

  // ---------------- response FIFO ----------------
  rsp_t           rslots [RSP_DEPTH];
  rsp_t           rsp_din, rsp_head;
  logic [SPW-1:0] rsp_rd_ptr, rsp_wr_ptr;
  logic [SPW:0]   rsp_cnt, rsp_cnt_n;

  assign mem_rsp_ready = ~rsp_full;
  assign rsp_push      = mem_rsp_valid & mem_rsp_ready;
  assign rsp_pop       = core_rsp_valid & core_rsp_ready;
  assign rsp_din       = {mem_rsp_tmask, mem_rsp_data, mem_rsp_tag};

  // Response occupancy after this cycle's push/pop.
  always_comb begin
    rsp_cnt_n = rsp_cnt;
    case ({rsp_push, rsp_pop})
      2'b10:   rsp_cnt_n = rsp_cnt + SC_ONE;
      2'b01:   rsp_cnt_n = rsp_cnt - SC_ONE;
      default: rsp_cnt_n = rsp_cnt;
    endcase
  end

  // Response pointers and registered flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_rd_ptr <= '0;
      rsp_wr_ptr <= '0;
      rsp_cnt    <= '0;
      rsp_empty  <= 1'b1;
      rsp_full   <= 1'b0;
    end else begin
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + SP_ONE;
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + SP_ONE;
      rsp_cnt   <= rsp_cnt_n;
      rsp_empty <= (rsp_cnt_n == '0);
      rsp_full  <= (rsp_cnt_n == SC_FULL);
    end
  end

  // Response storage.
  always_ff @(posedge clk) begin
    if (rsp_push) rslots[rsp_wr_ptr] <= rsp_din;
  end

  assign rsp_head       = rslots[rsp_rd_ptr];
  assign core_rsp_valid = ~rsp_empty;
  assign core_rsp_tmask = rsp_head.tmask;
  assign core_rsp_data  = rsp_head.data;
  assign core_rsp_tag   = rsp_head.tag;

  // ---------------- outstanding-read counter ----------------
  // Lanes entering as reads and lanes retired by the response this cycle.
  always_comb begin
    rd_inc  = '0;
    rsp_dec = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      rd_inc  = rd_inc  + PEND_W'(core_req_valid[i] & core_req_ready[i] & ~core_req_rw[i]);
      rsp_dec = rsp_dec + PEND_W'(mem_rsp_tmask[i]);
    end
  end

  // Increment and decrement can land in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= pending + rd_inc - (rsp_push ? rsp_dec : '0);
  end

  // A response never retires more read lanes than are outstanding.
  assert property (@(posedge clk) disable iff (reset)
    rsp_push |-> (({1'b0, pending} + {1'b0, rd_inc}) >= {1'b0, rsp_dec}));

  assign idle = (&req_empty) & rsp_empty & (pending == '0);
  assign busy = ~idle;

  // ---------------- drain / sleep FSM ----------------
  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_n;
  end

  // Next state: a dropped drain_req always wins over going to sleep.
  always_comb begin
    state_n = state;
    case (state)
      RUN:     if (drain_req) state_n = DRAIN;
      DRAIN:   if (!drain_req) state_n = RUN;
               else if (idle)  state_n = SLEEP;
      SLEEP:   if (!drain_req) state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  // Outputs decoded from the registered state.
  always_comb begin
    accept_en = (state == RUN);
    drain_ack = (state == SLEEP);
  end
endmodule

// File: tb/tb_vx_cache_port_relay.sv
// Bench for vx_cache_port_relay: reset checks, hand sequences, a step table
// for throttle/drain behaviour and a randomized run against a queue model.
module tb_vx_cache_port_relay;
  localparam int N  = 4;
  localparam int AW = 30;
  localparam int TW = 8;
  localparam int RD = 2;
  localparam int SD = 2;
  localparam int MP = 8;

  logic            clk, reset;
  logic [N-1:0]    core_req_valid, core_req_rw, core_req_ready;
  logic [N*4-1:0]  core_req_byteen, mem_req_byteen;
  logic [N*AW-1:0] core_req_addr, mem_req_addr;
  logic [N*32-1:0] core_req_data, mem_req_data;
  logic [N*TW-1:0] core_req_tag, mem_req_tag;
  logic [N-1:0]    mem_req_valid, mem_req_rw, mem_req_ready;
  logic            mem_rsp_valid, mem_rsp_ready;
  logic [N-1:0]    mem_rsp_tmask, core_rsp_tmask;
  logic [N*32-1:0] mem_rsp_data, core_rsp_data;
  logic [TW-1:0]   mem_rsp_tag, core_rsp_tag;
  logic            core_rsp_valid, core_rsp_ready;
  logic            drain_req, drain_ack, busy;

  vx_cache_port_relay #(.NUM_REQS(N), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
    .REQ_DEPTH(RD), .RSP_DEPTH(SD), .MAX_PENDING(MP)) dut (
    .clk(clk), .reset(reset),
    .core_req_valid(core_req_valid), .core_req_rw(core_req_rw),
    .core_req_byteen(core_req_byteen), .core_req_addr(core_req_addr),
    .core_req_data(core_req_data), .core_req_tag(core_req_tag),
    .core_req_ready(core_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tmask(mem_rsp_tmask),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready),
    .core_rsp_valid(core_rsp_valid), .core_rsp_tmask(core_rsp_tmask),
    .core_rsp_data(core_rsp_data), .core_rsp_tag(core_rsp_tag),
    .core_rsp_ready(core_rsp_ready),
    .drain_req(drain_req), .drain_ack(drain_ack), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  int checks = 0, errors = 0;

  task automatic chk(string name, logic [159:0] act, logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic          rw;
    logic [3:0]    be;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [TW-1:0] tag;
  } mreq_t;

  typedef struct packed {
    logic [N-1:0]    tm;
    logic [N*32-1:0] data;
    logic [TW-1:0]   tag;
  } mrsp_t;

  typedef struct packed {
    logic [3:0] rv, rw, mrdy;
    logic       rspv;
    logic [3:0] tm;
    logic       crdy, drain;
    logic [3:0] e_rdy, e_mvld;
    logic       e_rspv, e_mrrdy, e_ack, e_busy;
  } vec_t;

  function automatic vec_t v(logic [3:0] rv, logic [3:0] rw, logic [3:0] mrdy, logic rspv,
                             logic [3:0] tm, logic crdy, logic drain, logic [3:0] e_rdy,
                             logic [3:0] e_mvld, logic e_rspv, logic e_mrrdy, logic e_ack,
                             logic e_busy);
    return '{rv, rw, mrdy, rspv, tm, crdy, drain, e_rdy, e_mvld, e_rspv, e_mrrdy, e_ack, e_busy};
  endfunction

  function automatic mreq_t lane_req(int i);
    return {core_req_rw[i], core_req_byteen[i*4 +: 4], core_req_addr[i*AW +: AW],
            core_req_data[i*32 +: 32], core_req_tag[i*TW +: TW]};
  endfunction

  function automatic mreq_t lane_mem(int i);
    return {mem_req_rw[i], mem_req_byteen[i*4 +: 4], mem_req_addr[i*AW +: AW],
            mem_req_data[i*32 +: 32], mem_req_tag[i*TW +: TW]};
  endfunction

  task automatic idle();
    core_req_valid = '0; core_req_rw = '0; core_req_byteen = '0;
    core_req_addr = '0; core_req_data = '0; core_req_tag = '0;
    mem_req_ready = '1; mem_rsp_valid = 1'b0; mem_rsp_tmask = '0;
    mem_rsp_data = '0; mem_rsp_tag = '0; core_rsp_ready = 1'b1; drain_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle(); reset = 1'b1; core_req_valid = '1; core_req_rw = '1;
    #1 chk("rst.rdy_in_reset", core_req_ready, 4'h0);
    @(negedge clk);
    #1;
    chk("rst.mvld", mem_req_valid, 4'h0);
    chk("rst.rspv", core_rsp_valid, 1'b0);
    chk("rst.ack", drain_ack, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.rdy_held", core_req_ready, 4'h0);
    @(negedge clk);
    idle(); reset = 1'b0;
    #1 chk("rst.rdy_after", core_req_ready, 4'hF);
  endtask

  vec_t  tbl[$];
  mreq_t rq[N][$];
  mrsp_t sq[$];
  int    pend;

  initial begin
    reset = 1'b1;
    idle();
    do_reset();

    // ---- single-lane read and its response ----
    @(negedge clk);
    core_req_valid = 4'b0001; core_req_addr[AW-1:0] = AW'(32'h100); core_req_tag[TW-1:0] = 8'd5;
    #1 chk("sl.rdy", core_req_ready[0], 1'b1);
    chk("sl.mvld0", mem_req_valid, 4'h0);
    @(negedge clk);
    core_req_valid = '0;
    #1 chk("sl.mvld1", mem_req_valid, 4'b0001);
    chk("sl.addr", mem_req_addr[AW-1:0], 32'h100);
    chk("sl.tag", mem_req_tag[TW-1:0], 8'd5);
    chk("sl.rw", mem_req_rw[0], 1'b0);
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_tmask = 4'b0001; mem_rsp_data[31:0] = 32'hDEADBEEF; mem_rsp_tag = 8'd5;
    #1 chk("sl.mvld2", mem_req_valid, 4'h0);
    chk("sl.mrsp_rdy", mem_rsp_ready, 1'b1);
    chk("sl.busy", busy, 1'b1);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1 chk("sl.rspv", core_rsp_valid, 1'b1);
    chk("sl.rsp", {core_rsp_tmask, core_rsp_data[31:0], core_rsp_tag}, {4'b0001, 32'hDEADBEEF, 8'd5});
    @(negedge clk);
    #1 chk("sl.rspv_done", core_rsp_valid, 1'b0);
    chk("sl.idle", busy, 1'b0);

    // ---- backpressure on lane 2 ----
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_req_ready = '0; core_req_valid = 4'b0100;
      core_req_addr[2*AW +: AW] = AW'(32'h200 + k);
      #1 chk($sformatf("bp.rdy%0d", k), core_req_ready[2], (k < 2) ? 1'b1 : 1'b0);
      if (k > 0) chk($sformatf("bp.head%0d", k), mem_req_addr[2*AW +: AW], 32'h200);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      core_req_valid = '0; mem_req_ready = 4'b0100;
      #1 chk($sformatf("bp.mvld%0d", k), mem_req_valid[2], (k < 2) ? 1'b1 : 1'b0);
      if (k < 2) chk($sformatf("bp.order%0d", k), mem_req_addr[2*AW +: AW], 32'h200 + k);
      if (k > 0) chk($sformatf("bp.rdy_back%0d", k), core_req_ready[2], 1'b1);
    end

    // ---- reset with full FIFOs and 6 reads outstanding ----
    @(negedge clk);
    idle(); mem_req_ready = '0; core_req_valid = 4'hF;
    @(negedge clk);
    core_req_valid = 4'b0011;
    @(negedge clk);
    core_req_valid = '0;
    #1 chk("mr.busy_before", busy, 1'b1);
    chk("mr.full_lanes", core_req_ready & 4'b0011, 4'b0000);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; idle();
    #1 chk("mr.mvld", mem_req_valid, 4'h0);
    chk("mr.rspv", core_rsp_valid, 1'b0);
    chk("mr.busy", busy, 1'b0);
    chk("mr.rdy", core_req_ready, 4'hF);
    core_req_valid = 4'hF;
    @(negedge clk);
    #1 chk("mr.pending_cleared", core_req_ready, 4'hF);

    // ---- throttle / drain / abort step table ----
    tbl.push_back(v(4'hF,4'h0,4'hF,0,4'h0,1,0, 4'hF,4'h0,0,1,0,0));
    tbl.push_back(v(4'hF,4'h0,4'hF,0,4'h0,1,0, 4'hF,4'hF,0,1,0,1));
    tbl.push_back(v(4'hF,4'h0,4'hF,0,4'h0,1,0, 4'h0,4'hF,0,1,0,1));
    tbl.push_back(v(4'hF,4'hF,4'hF,0,4'h0,1,0, 4'hF,4'h0,0,1,0,1));
    tbl.push_back(v(4'h1,4'h0,4'hF,1,4'hF,1,0, 4'h0,4'hF,0,1,0,1));
    tbl.push_back(v(4'h1,4'h0,4'hF,0,4'h0,1,0, 4'hF,4'h0,1,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,0, 4'h0,4'h1,0,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,1,4'hF,1,0, 4'h0,4'h0,0,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,1,4'h1,1,0, 4'hF,4'h0,1,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,0, 4'hF,4'h0,1,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,0, 4'hF,4'h0,0,1,0,0));
    tbl.push_back(v(4'h3,4'h0,4'hF,0,4'h0,1,0, 4'hF,4'h0,0,1,0,0));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,1, 4'hF,4'h3,0,1,0,1));
    tbl.push_back(v(4'hF,4'hF,4'hF,0,4'h0,1,1, 4'h0,4'h0,0,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,1,4'h3,0,1, 4'h0,4'h0,0,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,0,1, 4'h0,4'h0,1,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,1, 4'h0,4'h0,1,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,1, 4'h0,4'h0,0,1,0,0));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,1, 4'h0,4'h0,0,1,1,0));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,0, 4'h0,4'h0,0,1,1,0));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,0, 4'hF,4'h0,0,1,0,0));
    tbl.push_back(v(4'h1,4'h0,4'hF,0,4'h0,1,0, 4'hF,4'h0,0,1,0,0));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,1, 4'hF,4'h1,0,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,0, 4'h0,4'h0,0,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,1,4'h1,1,0, 4'hF,4'h0,0,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,0, 4'hF,4'h0,1,1,0,1));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,1, 4'hF,4'h0,0,1,0,0));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,0, 4'h0,4'h0,0,1,0,0));
    tbl.push_back(v(4'h0,4'h0,4'hF,0,4'h0,1,0, 4'hF,4'h0,0,1,0,0));

    do_reset();
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      core_req_valid = tbl[k].rv; core_req_rw = tbl[k].rw; mem_req_ready = tbl[k].mrdy;
      mem_rsp_valid = tbl[k].rspv; mem_rsp_tmask = tbl[k].tm;
      core_rsp_ready = tbl[k].crdy; drain_req = tbl[k].drain;
      #1;
      chk($sformatf("tbl%0d.rdy", k), core_req_ready, tbl[k].e_rdy);
      chk($sformatf("tbl%0d.mvld", k), mem_req_valid, tbl[k].e_mvld);
      chk($sformatf("tbl%0d.rspv", k), core_rsp_valid, tbl[k].e_rspv);
      chk($sformatf("tbl%0d.mrsp_rdy", k), mem_rsp_ready, tbl[k].e_mrrdy);
      chk($sformatf("tbl%0d.ack", k), drain_ack, tbl[k].e_ack);
      chk($sformatf("tbl%0d.busy", k), busy, tbl[k].e_busy);
    end

    // ---- randomized traffic against a queue model ----
    do_reset();
    pend = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] erdy;
      int           reads, dec;
      logic         rpush;
      @(negedge clk);
      core_req_valid = N'($urandom);
      core_req_rw    = N'($urandom);
      mem_req_ready  = N'($urandom);
      core_rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        core_req_byteen[i*4 +: 4] = 4'($urandom);
        core_req_addr[i*AW +: AW] = AW'($urandom);
        core_req_data[i*32 +: 32] = $urandom;
        core_req_tag[i*TW +: TW]  = TW'($urandom);
        mem_rsp_data[i*32 +: 32]  = $urandom;
      end
      mem_rsp_tmask = N'($urandom);
      mem_rsp_tag   = TW'($urandom);
      dec = $countones(mem_rsp_tmask);
      mem_rsp_valid = ($urandom_range(0, 1) == 1) && (dec <= pend);
      #1;
      for (int i = 0; i < N; i++)
        erdy[i] = (rq[i].size() < RD) && (core_req_rw[i] || pend <= MP - N);
      chk("rnd.rdy", core_req_ready, erdy);
      for (int i = 0; i < N; i++) begin
        chk("rnd.mvld", mem_req_valid[i], rq[i].size() > 0);
        if (rq[i].size() > 0) chk("rnd.mreq", lane_mem(i), rq[i][0]);
      end
      chk("rnd.mrsp_rdy", mem_rsp_ready, sq.size() < SD);
      chk("rnd.rspv", core_rsp_valid, sq.size() > 0);
      if (sq.size() > 0) chk("rnd.rsp", {core_rsp_tmask, core_rsp_data, core_rsp_tag}, sq[0]);
      chk("rnd.busy", busy, (pend != 0) || (sq.size() != 0) || (rq[0].size() + rq[1].size() +
                             rq[2].size() + rq[3].size() != 0));
      // Advance the model across the coming clock edge.
      reads = 0;
      for (int i = 0; i < N; i++) begin
        if (mem_req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        if (core_req_valid[i] && erdy[i]) begin
          rq[i].push_back(lane_req(i));
          if (!core_req_rw[i]) reads++;
        end
      end
      rpush = mem_rsp_valid && (sq.size() < SD);
      if (core_rsp_ready && sq.size() > 0) void'(sq.pop_front());
      if (rpush) sq.push_back({mem_rsp_tmask, mem_rsp_data, mem_rsp_tag});
      pend = pend + reads - (rpush ? dec : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
